// File: rtl/roce_arb_pkg.sv
// Shared definitions for the RoCE TX request arbiter.
//   TXM_INLINE_BIT : bit of the TX command word that flags an inline payload
//   arb_state_t    : arbiter FSM encoding
//   rr_pick        : round-robin pick over up to RR_MAX requesters
package roce_arb_pkg;

  localparam int TXM_INLINE_BIT = 159;
  localparam int RR_MAX         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Returns the first valid index after 'last', wrapping modulo n. Returns
  // 'last' when nothing is valid; callers qualify with their own found flag.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0]        last,
                                         input int                n = RR_MAX);
    logic [2:0] idx;
    rr_pick = last;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = 3'((int'(last) + k) % n);
        if (valid[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick.
//   valid : request vector
//   last  : index granted most recently; search starts at last+1
//   sel   : chosen index (meaningful only when found=1)
//   found : at least one request is valid
module rr_arbiter
  import roce_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] sel,
  output logic           found
);

  logic [RR_MAX-1:0] valid_ext;
  logic [2:0]        pick;
  logic              unused_pick;

  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = valid;
  end

  assign pick        = rr_pick(valid_ext, 3'(last), N);
  assign sel         = pick[IDW-1:0];
  assign unused_pick = ^pick;
  assign found       = |valid;

endmodule

// File: rtl/roce_tx_req_arbiter.sv
// Shares the RoCE stack's single TX command path between N_REQ requesters.
// A requester wins the command slot round-robin, its command is registered
// and offered to the stack, and if the command carries inline payload the
// grant stays locked while that requester's payload streams through a
// combinational mux until the last beat.
//
//   state | meaning
//   IDLE  | arbitrate; accept one command from the selected requester
//   META  | offer the registered command until the stack accepts it
//   DATA  | pass the granted requester's payload stream to the stack
//
// Ports:
//   net_clk, net_aresetn         : clock, async active-low reset
//   req_meta_* (per requester)   : command handshake and packed command words
//   req_data_* (per requester)   : payload streams, packed per lane
//   m_tx_meta_*                  : command toward the stack (registered)
//   m_tx_data_*                  : payload toward the stack (muxed)
//   grant_id                     : current or last granted requester
//   busy                         : FSM is not in IDLE
module roce_tx_req_arbiter
  import roce_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int META_W = 160,
  parameter int DATA_W = 512
) (
  input  logic                        net_clk,
  input  logic                        net_aresetn,
  input  logic [N_REQ-1:0]            req_meta_valid,
  output logic [N_REQ-1:0]            req_meta_ready,
  input  logic [N_REQ*META_W-1:0]     req_meta_data,
  input  logic [N_REQ-1:0]            req_data_valid,
  output logic [N_REQ-1:0]            req_data_ready,
  input  logic [N_REQ*DATA_W-1:0]     req_data_data,
  input  logic [N_REQ*DATA_W/8-1:0]   req_data_keep,
  input  logic [N_REQ-1:0]            req_data_last,
  output logic                        m_tx_meta_valid,
  input  logic                        m_tx_meta_ready,
  output logic [META_W-1:0]           m_tx_meta_data,
  output logic                        m_tx_data_valid,
  input  logic                        m_tx_data_ready,
  output logic [DATA_W-1:0]           m_tx_data_data,
  output logic [DATA_W/8-1:0]         m_tx_data_keep,
  output logic                        m_tx_data_last,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy
);

  localparam int IDW     = $clog2(N_REQ);
  localparam int KEEP_W  = DATA_W / 8;
  localparam int INL_BIT = (TXM_INLINE_BIT < META_W) ? TXM_INLINE_BIT : META_W - 1;

  arb_state_t        state_q;
  logic [IDW-1:0]    last_q;
  logic [IDW-1:0]    grant_q;
  logic [META_W-1:0] meta_q;
  logic              meta_valid_q;
  logic              run_q;
  logic [IDW-1:0]    sel;
  logic              found;
  logic              accept;

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
    .valid (req_meta_valid),
    .last  (last_q),
    .sel   (sel),
    .found (found)
  );

  // run_q holds arbitration off until the first edge after reset release,
  // so no command is accepted while the block is still coming out of reset.
  assign accept = run_q && (state_q == IDLE) && found;

  always_comb begin
    req_meta_ready = '0;
    if (accept) req_meta_ready[sel] = 1'b1;
  end

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      state_q      <= IDLE;
      last_q       <= IDW'(N_REQ - 1);
      grant_q      <= '0;
      meta_q       <= '0;
      meta_valid_q <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            meta_q       <= req_meta_data[sel*META_W +: META_W];
            meta_valid_q <= 1'b1;
            last_q       <= sel;
            grant_q      <= sel;
            state_q      <= META;
          end
        end
        META: begin
          if (m_tx_meta_ready) begin
            meta_valid_q <= 1'b0;
            state_q      <= meta_q[INL_BIT] ? DATA : IDLE;
          end
        end
        DATA: begin
          if (m_tx_data_valid && m_tx_data_ready && m_tx_data_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Payload mux: data/keep always follow the granted lane; valid, last and
  // the per-lane readies are only opened while in DATA.
  always_comb begin
    req_data_ready  = '0;
    m_tx_data_valid = 1'b0;
    m_tx_data_last  = 1'b0;
    m_tx_data_data  = req_data_data[grant_q*DATA_W +: DATA_W];
    m_tx_data_keep  = req_data_keep[grant_q*KEEP_W +: KEEP_W];
    if (state_q == DATA) begin
      req_data_ready[grant_q] = m_tx_data_ready;
      m_tx_data_valid         = req_data_valid[grant_q];
      m_tx_data_last          = req_data_last[grant_q];
    end
  end

  assign m_tx_meta_valid = meta_valid_q;
  assign m_tx_meta_data  = meta_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_roce_tx_req_arbiter.sv
module tb_roce_tx_req_arbiter;

  localparam int N  = 4;
  localparam int MW = 160;
  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic              net_clk = 1'b0;
  logic              net_aresetn;
  logic [N-1:0]      req_meta_valid;
  logic [N-1:0]      req_meta_ready;
  logic [N*MW-1:0]   req_meta_data;
  logic [N-1:0]      req_data_valid;
  logic [N-1:0]      req_data_ready;
  logic [N*DW-1:0]   req_data_data;
  logic [N*KW-1:0]   req_data_keep;
  logic [N-1:0]      req_data_last;
  logic              m_tx_meta_valid;
  logic              m_tx_meta_ready;
  logic [MW-1:0]     m_tx_meta_data;
  logic              m_tx_data_valid;
  logic              m_tx_data_ready;
  logic [DW-1:0]     m_tx_data_data;
  logic [KW-1:0]     m_tx_data_keep;
  logic              m_tx_data_last;
  logic [1:0]        grant_id;
  logic              busy;

  typedef struct {
    logic [MW-1:0] meta;
    logic [1:0]    lane;
  } meta_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } data_exp_t;

  meta_exp_t     sb_meta[$];
  data_exp_t     sb_data[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [MW-1:0] word [N];

  always #5 net_clk = ~net_clk;

  roce_tx_req_arbiter #(.N_REQ(N), .META_W(MW), .DATA_W(DW)) dut (
    .net_clk         (net_clk),
    .net_aresetn     (net_aresetn),
    .req_meta_valid  (req_meta_valid),
    .req_meta_ready  (req_meta_ready),
    .req_meta_data   (req_meta_data),
    .req_data_valid  (req_data_valid),
    .req_data_ready  (req_data_ready),
    .req_data_data   (req_data_data),
    .req_data_keep   (req_data_keep),
    .req_data_last   (req_data_last),
    .m_tx_meta_valid (m_tx_meta_valid),
    .m_tx_meta_ready (m_tx_meta_ready),
    .m_tx_meta_data  (m_tx_meta_data),
    .m_tx_data_valid (m_tx_data_valid),
    .m_tx_data_ready (m_tx_data_ready),
    .m_tx_data_data  (m_tx_data_data),
    .m_tx_data_keep  (m_tx_data_keep),
    .m_tx_data_last  (m_tx_data_last),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] new_meta(input int lane, input logic inl);
    logic [MW-1:0] m;
    for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
    m[7:0]    = 8'(lane);
    m[MW-1]   = inl;
    return m;
  endfunction

  task automatic set_meta(input int lane, input logic inl);
    word[lane] = new_meta(lane, inl);
    req_meta_data[lane*MW +: MW] = word[lane];
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive_beat(input int lane, input logic last, input bit push);
    data_exp_t e;
    e.data = rand_data();
    e.keep = {$urandom, $urandom};
    e.last = last;
    req_data_valid[lane]         = 1'b1;
    req_data_data[lane*DW +: DW] = e.data;
    req_data_keep[lane*KW +: KW] = e.keep;
    req_data_last[lane]          = last;
    if (push) sb_data.push_back(e);
  endtask

  task automatic reset_dut();
    net_aresetn     = 1'b0;
    req_meta_valid  = '0;
    req_data_valid  = '0;
    req_data_last   = '0;
    m_tx_meta_ready = 1'b1;
    m_tx_data_ready = 1'b0;
    #12;
    @(posedge net_clk); #1;
    net_aresetn = 1'b1;
    @(posedge net_clk); #1;
  endtask

  // At posedge+1 in IDLE: expect 'lane' to be accepted this cycle.
  task automatic expect_accept(input string tag, input int lane);
    logic [N-1:0] oh;
    oh = '0;
    oh[lane] = 1'b1;
    @(negedge net_clk);
    chk(tag, req_meta_ready, oh);
    sb_meta.push_back('{word[lane], 2'(lane)});
    @(posedge net_clk); #1;
  endtask

  // At posedge+1 in META with m_tx_meta_ready=1: the command goes out.
  task automatic meta_phase(input string tag);
    @(negedge net_clk);
    chk(tag, {busy, m_tx_meta_valid, req_meta_ready}, {1'b1, 1'b1, 4'b0000});
    @(posedge net_clk); #1;
  endtask

  // At posedge+1 in DATA: stream nbeats from lane; stop early after
  // abort_after handshakes when non-zero (the next beat is left undelivered).
  task automatic run_payload(input int lane, input int nbeats, input bit rnd, input int abort_after);
    int           j;
    int           cyc;
    logic         hs;
    logic [N-1:0] oh;
    j   = 0;
    cyc = 0;
    drive_beat(lane, nbeats == 1, 1'b1);
    while (j < nbeats && cyc < 200) begin
      m_tx_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge net_clk);
      oh = '0;
      oh[lane] = m_tx_data_ready;
      chk("pt_ready", req_data_ready, oh);
      chk("meta_rdy_lock", req_meta_ready, 4'b0000);
      hs = req_data_valid[lane] && req_data_ready[lane];
      @(posedge net_clk); #1;
      cyc++;
      if (hs) begin
        j++;
        if (abort_after != 0 && j == abort_after) begin
          drive_beat(lane, 1'b0, 1'b0);
          break;
        end
        if (j < nbeats) drive_beat(lane, j == nbeats - 1, 1'b1);
        else req_data_valid[lane] = 1'b0;
      end
    end
    chk("payload_progress", 32'(j), (abort_after != 0) ? 32'(abort_after) : 32'(nbeats));
    if (abort_after == 0) m_tx_data_ready = 1'b0;
  endtask

  // Scoreboard pop side: every stack-side handshake is checked in order.
  always @(negedge net_clk) begin : mon
    meta_exp_t me;
    data_exp_t de;
    if (net_aresetn === 1'b1) begin
      if (m_tx_meta_valid && m_tx_meta_ready) begin
        chk("meta_pending", sb_meta.size() != 0, 1'b1);
        if (sb_meta.size() != 0) begin
          me = sb_meta.pop_front();
          chk("meta_word", m_tx_meta_data, me.meta);
          chk("meta_grant", grant_id, me.lane);
        end
      end
      if (m_tx_data_valid && m_tx_data_ready) begin
        chk("data_pending", sb_data.size() != 0, 1'b1);
        if (sb_data.size() != 0) begin
          de = sb_data.pop_front();
          chk("data_word", m_tx_data_data, de.data);
          chk("data_keep", m_tx_data_keep, de.keep);
          chk("data_last", m_tx_data_last, de.last);
        end
      end
    end
  end

  initial begin
    req_meta_data = '0;
    req_data_data = '0;
    req_data_keep = '0;
    for (int i = 0; i < N; i++) word[i] = '0;

    // Reset values, with every requester asking during reset.
    net_aresetn     = 1'b0;
    req_meta_valid  = 4'hF;
    req_data_valid  = 4'hF;
    req_data_last   = '0;
    m_tx_meta_ready = 1'b1;
    m_tx_data_ready = 1'b1;
    #12;
    chk("rst_meta_valid", m_tx_meta_valid, 1'b0);
    chk("rst_meta_data", m_tx_meta_data, '0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_meta_rdy", req_meta_ready, 4'b0000);
    chk("rst_data_rdy", {m_tx_data_valid, req_data_ready}, 5'b0);
    reset_dut();

    // Single meta-only command from requester 2.
    set_meta(2, 1'b0);
    req_meta_valid = 4'b0100;
    @(negedge net_clk);
    chk("lat_pre_valid", m_tx_meta_valid, 1'b0);
    chk("t1_accept", req_meta_ready, 4'b0100);
    sb_meta.push_back('{word[2], 2'd2});
    @(posedge net_clk); #1;
    req_meta_valid = '0;
    @(negedge net_clk);
    chk("t1_meta_valid", m_tx_meta_valid, 1'b1);
    chk("t1_grant", grant_id, 2'd2);
    @(posedge net_clk); #1;
    @(negedge net_clk);
    chk("t1_idle", {busy, m_tx_data_valid}, 2'b00);

    // Strict rotation with all requesters valid, one command per 2 cycles.
    reset_dut();
    for (int i = 0; i < N; i++) set_meta(i, 1'b0);
    req_meta_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      expect_accept("rr_accept", k % N);
      set_meta(k % N, 1'b0);
      meta_phase("rr_meta");
    end
    req_meta_valid = '0;

    // Requester 1 inline 3 beats while requester 0 waits.
    set_meta(1, 1'b1);
    req_meta_valid = 4'b0010;
    expect_accept("t3_accept1", 1);
    set_meta(0, 1'b0);
    req_meta_valid = 4'b0011;
    req_meta_valid[1] = 1'b0;
    meta_phase("t3_meta1");
    run_payload(1, 3, 1'b0, 0);
    expect_accept("t3_accept0_after_last", 0);
    req_meta_valid = '0;
    meta_phase("t3_meta0");

    // Stack stalls the command for 10 cycles.
    m_tx_meta_ready = 1'b0;
    set_meta(3, 1'b0);
    req_meta_valid = 4'b1000;
    expect_accept("t4_accept3", 3);
    req_meta_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge net_clk);
      chk("stall_data", m_tx_meta_data, word[3]);
      chk("stall_rdy", {m_tx_meta_valid, req_meta_ready}, 5'b10000);
      @(posedge net_clk); #1;
    end
    m_tx_meta_ready = 1'b1;
    req_meta_valid  = '0;
    @(posedge net_clk); #1;

    // 16-beat payload under random stack backpressure.
    set_meta(0, 1'b1);
    req_meta_valid = 4'b0001;
    expect_accept("t5_accept0", 0);
    req_meta_valid = '0;
    meta_phase("t5_meta0");
    run_payload(0, 16, 1'b1, 0);
    @(negedge net_clk);
    chk("t5_idle", busy, 1'b0);
    @(posedge net_clk); #1;

    // Reset in the middle of a payload.
    set_meta(2, 1'b1);
    req_meta_valid = 4'b0100;
    expect_accept("t6_accept2", 2);
    req_meta_valid = '0;
    meta_phase("t6_meta2");
    run_payload(2, 5, 1'b0, 2);
    req_meta_valid = 4'b0101;
    net_aresetn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_meta", {m_tx_meta_valid, m_tx_meta_data}, '0);
    chk("mid_rst_grant", grant_id, 2'd0);
    chk("mid_rst_rdy", {m_tx_data_valid, req_data_ready, req_meta_ready}, 9'b0);
    m_tx_data_ready = 1'b0;
    reset_dut();
    set_meta(0, 1'b0);
    set_meta(2, 1'b0);
    req_meta_valid = 4'b0101;
    for (int w = 0; w < 4; w++) begin
      @(negedge net_clk);
      if (req_meta_ready != '0) break;
    end
    chk("post_rst_prio", req_meta_ready, 4'b0001);
    sb_meta.push_back('{word[0], 2'd0});
    @(posedge net_clk); #1;
    req_meta_valid = '0;
    meta_phase("t6_meta0");

    chk("sb_meta_empty", 32'(sb_meta.size()), 32'd0);
    chk("sb_data_empty", 32'(sb_data.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/roce_tx_req_arbiter.md
# roce_tx_req_arbiter

Round-robin arbiter that shares the RoCE stack's single TX command path (`tx_meta` plus the inline `tx_data` stream) between `N_REQ` independent requesters, e.g. host queue, pointer-chasing engine and a control unit. Each requester presents an RDMA command and, when the command carries inline payload, a payload stream. The arbiter grants one requester at a time and forwards its command. It keeps the grant locked until that command's payload has fully drained. It sits directly in front of the RoCE stack's `s_axis_tx_meta` / `s_axis_tx_data` slave ports in `net_clk`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `META_W`, default 160: width of the TX command word.
- `DATA_W`, default 512: payload width; keep width is `DATA_W/8`.

Ports:
- `net_clk`, in, 1: single clock.
- `net_aresetn`, in, 1: asynchronous active-low reset.
- `req_meta_valid`, in, `N_REQ`: per-requester command valid.
- `req_meta_ready`, out, `N_REQ`: per-requester command accept.
- `req_meta_data`, in, `N_REQ*META_W`: command words; requester i occupies bits `[i*META_W +: META_W]`.
- `req_data_valid`, in, `N_REQ`: per-requester payload valid.
- `req_data_ready`, out, `N_REQ`: per-requester payload ready.
- `req_data_data`, in, `N_REQ*DATA_W`: payload data, packed like `req_meta_data`.
- `req_data_keep`, in, `N_REQ*DATA_W/8`: payload byte keep.
- `req_data_last`, in, `N_REQ`: payload last beat.
- `m_tx_meta_valid`, out, 1: command valid toward the stack.
- `m_tx_meta_ready`, in, 1: stack accepts the command.
- `m_tx_meta_data`, out, `META_W`: granted command word.
- `m_tx_data_valid`, out, 1: payload valid toward the stack.
- `m_tx_data_ready`, in, 1: stack accepts payload.
- `m_tx_data_data`, out, `DATA_W`: payload data.
- `m_tx_data_keep`, out, `DATA_W/8`: payload keep.
- `m_tx_data_last`, out, 1: payload last.
- `grant_id`, out, `$clog2(N_REQ)`: index of the current or last granted requester.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, META, DATA.
- IDLE:
  - Round-robin selection over `req_meta_valid`, starting at `(last_grant+1) mod N_REQ`.
  - When any request is valid: pulse `req_meta_ready[sel]` for that cycle, register the command word into the output register, set `last_grant = sel`, and go to META.
- META:
  - Hold `m_tx_meta_valid=1` with stable data until `m_tx_meta_ready`.
  - On handshake, go to DATA if the command's inline flag `meta[TXM_INLINE_BIT]` is 1, otherwise go to IDLE.
- DATA:
  - Combinational pass-through of requester `grant_id`: `m_tx_data_*` come from that lane, and `req_data_ready[grant_id] = m_tx_data_ready`.
  - All other lanes see `req_data_ready=0`.
  - On a handshake with last=1, go to IDLE.
- Outside DATA: `m_tx_data_valid=0` and every `req_data_ready` is 0. Payload presented early is simply held off by backpressure.
- `req_meta_ready` is high only for one cycle, only in IDLE, and only for the selected lane.
- Requester meta-valid lines are not required to stay high until granted. A requester that drops valid is simply skipped.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - FSM = IDLE.
  - `last_grant = N_REQ-1`, so requester 0 wins first.
  - `m_tx_meta_valid=0`, `m_tx_meta_data=0`.
  - `grant_id=0`, `busy=0`.
  - All ready outputs 0.
- Latency: request accepted in cycle t; `m_tx_meta_valid` rises at t+1.
- Throughput: peak is one meta-only command every 2 cycles (IDLE and META alternate).
- Payload: zero added latency, full throughput (combinational mux).
- A single-beat payload returns the FSM to IDLE in the cycle after its handshake.
- Simultaneous requests: strict rotation. With all `N_REQ` valid continuously, grants go 0,1,…,N_REQ-1,0.
- A new request arriving during META or DATA waits. Arbitration is evaluated only in IDLE.
- Reset mid-transfer drops the command/payload in flight. Requesters are reset by the same `net_aresetn`.
- The grant-mux paths (`m_tx_data_ready` → `req_data_ready`, lane data → `m_tx_data_*`) are combinational. No other combinational in→out path exists.

## Structure
- Shared package `roce_arb_pkg` holds:
  - `TXM_INLINE_BIT`, the inline-payload flag position in the TX command word; value 159 for the default `META_W`.
  - The FSM state enum `arb_state_t` (IDLE/META/DATA).
  - The function `rr_pick(valid, last)` returning the next index.
- One sub-module, `rr_arbiter`, is natural: a purely combinational N-way round-robin pick with a `found` output, reusable by other shared ports in the design.

## Test plan
- Reset then a single requester 2 sending a meta-only command (inline=0): `m_tx_meta_valid` rises 1 cycle after acceptance with data equal to requester 2's word, `grant_id=2`, and the FSM returns to IDLE; no data beats.
- All 4 requesters continuously valid with meta-only commands and `m_tx_meta_ready=1`: grant sequence 0,1,2,3,0,1 and one command every 2 cycles.
- Requester 1 sends an inline command with a 3-beat payload while requester 0 is also valid:
  - Requester 1's beats pass through unchanged.
  - `req_data_ready[0]` stays 0 throughout.
  - Requester 0 is granted only after requester 1's last beat.
- `m_tx_meta_ready` held low for 10 cycles: `m_tx_meta_data` stays stable and `req_meta_ready` stays 0 for all lanes.
- Random `m_tx_data_ready` toggling during a 16-beat payload: every beat is delivered exactly once and in order, and keep and last match the input.
- Assert `net_aresetn` in DATA mid-payload: all outputs return to reset values immediately, and after release requester 0 has priority.
